sd_dfc_mrctx: RTL and testbench
===============================

# sd_dfc_mrctx

Multi-channel delayed-flow-control transmitter with per-channel rate control and flow-control monitoring. It accepts `channels` independent srdy/drdy streams, holds one word per channel, and arbitrates them round-robin onto one shared DFC link. Each channel has its own `p_fc_n` bit on that link (virtual channels). It sits at the sender edge of a DFC link, between channel-side srdy/drdy logic and the registered link wires. It is the multi-channel successor of the single-stream rate-controlled DFC transmitter.

## Interface
- `channels`, 4: number of virtual channels, 2..16.
- `width`, 8: data width per word.
- `rc_ctr_sz`, 8: width of the window, transfer and flow-control counters.
- `chan_sz`, `$clog2(channels)`: width of `p_chan` (derived).

- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `window_size`  in  `rc_ctr_sz`  window length in cycles; 0 is treated as 1.
- `rc_max_tx`  in  `channels*rc_ctr_sz`  per-channel maximum transfers per window; slice k = channel k; 0 = unlimited.
- `mon_fc_thd`  in  `channels*rc_ctr_sz`  per-channel threshold of flow-controlled cycles per window.
- `mon_triggered`  out  `channels`  per-channel monitor flag.
- `c_srdy`  in  `channels`  channel-side source ready.
- `c_drdy`  out  `channels`  channel-side destination ready.
- `c_data`  in  `channels*width`  channel-side data; slice k = channel k.
- `p_vld`  out  1  link word valid.
- `p_chan`  out  `chan_sz`  channel id of the link word.
- `p_data`  out  `width`  link data.
- `p_fc_n`  in  `channels`  per-channel link flow control; 1 = may send.

## Operation
- Flow-control register: `fc_q[k] <= p_fc_n[k]` every cycle. Reset value 0.
- Holding register per channel: `hold_vld[k]` and `hold_data[k]`.
  - `c_drdy[k] = ~hold_vld[k] | grant[k]`.
  - On `c_srdy[k] & c_drdy[k]`, load `c_data[k]` and set `hold_vld[k]`.
  - Otherwise, on `grant[k]`, clear `hold_vld[k]`.
- Eligibility: `elig[k] = hold_vld[k] & fc_q[k] & ~limit[k]`.
  - `limit[k] = (rc_max_tx[k] != 0) & (tx_ctr[k] >= rc_max_tx[k])`.
- Arbiter: round-robin over `elig`, one grant per cycle.
  - Priority starts at `rr_ptr` and searches upward modulo `channels`.
  - After a grant to channel k, `rr_ptr <= (k+1) mod channels`.
  - `rr_ptr` reset value 0.
- Link outputs:
  - `p_vld = |grant`.
  - `p_chan` = index of the granted channel; 0 when idle.
  - `p_data = hold_data[granted]`; 0 when idle.
- Window counter:
  - `win_ctr` counts 0..`window_size`-1, then wraps to 0. Reset value 0.
  - `wrap` = the cycle in which `win_ctr == window_size-1`, with size 0 treated as 1.
- Transfer counter `tx_ctr[k]`:
  - On `wrap`, set to 0. The grant in the wrap cycle still counts toward the old window.
  - Otherwise, increment on `grant[k]`, saturating at all-ones.
- Flow-control counter `fc_ctr[k]`:
  - Increments on `hold_vld[k] & ~fc_q[k]`, saturating at all-ones.
  - On `wrap`, set to 0.
- `mon_triggered[k]`:
  - Set when `fc_ctr[k] > mon_fc_thd[k]`.
  - Holds for the rest of the window.
  - Cleared registered on `wrap`; a set condition in the wrap cycle is dropped.
- Changing configuration inputs mid-window takes effect the next cycle. The window counter is not restarted, except that a `win_ctr` at or beyond a new, smaller `window_size` forces `wrap`.

## Timing
- DFC rule: a word for channel k is sent only if `p_fc_n[k]` was high in the previous cycle (`p_vld & p_chan==k |-> $past(p_fc_n[k])`).
- Latency from `c_srdy` acceptance to `p_vld`: 1 cycle minimum.
- Throughput: one word per cycle aggregate. A single channel sustains one word per cycle because its holding register refills in the cycle it is granted.
- `p_vld`, `p_chan` and `p_data` are decoded from registers only: `hold_*`, `fc_q`, counters and `rr_ptr`. There is no path from `p_fc_n` to them.
- Reset values: `c_drdy` all 1 (holding registers empty); `p_vld`, `p_chan`, `p_data` and `mon_triggered` all 0. Every register clears asynchronously.
- Reset asserted mid-operation discards held words. The first possible `p_vld` is 2 cycles after reset release, because `fc_q` must load 1 first.
- Simultaneous grant and reload on one channel is legal; the new word is presented the next cycle.

## Configuration
- `SD_DFC_MRCTX_MON_EN` defined: `fc_ctr` and `mon_triggered` logic are present as above.
- `SD_DFC_MRCTX_MON_EN` undefined: `fc_ctr` is removed, `mon_triggered` is tied to 0, and `mon_fc_thd` is ignored.
- Rate limiting is unaffected either way.

## Structure
- Shared package `sd_dfc_pkg` holds:
  - the channel-id width function;
  - the counter saturation-increment function;
  - the "0 means unlimited/1" normalisation helpers.
- Sub-module `sd_dfc_rc_chan`, one instance per channel in a generate loop, contains:
  - the holding register;
  - `tx_ctr`, `fc_ctr` and `mon_triggered`;
  - the `elig` output.
- Top level contains the window counter, `fc_q`, the round-robin arbiter and the output mux.

## Test plan
- `channels`=4; all `c_srdy`=1; `p_fc_n`=4'hF; `rc_max_tx`=0 → `p_chan` cycles 0,1,2,3,0,… one word per cycle from cycle 2 after reset.
- `window_size`=10; `rc_max_tx[1]`=3; only channel 1 active → exactly 3 words per 10-cycle window; `c_drdy[1]`=0 while `limit` is active.
- Drop `p_fc_n[2]` at cycle t → no word with `p_chan`=2 at t+1 or later until `p_fc_n[2]` rises; other channels are unaffected.
- `SD_DFC_MRCTX_MON_EN`; `window_size`=16; `mon_fc_thd[0]`=4; `p_fc_n[0]`=0 with channel 0 held → `mon_triggered[0]` rises in the cycle after `fc_ctr[0]` reaches 5 and clears after `wrap`.
- Assert `rst` with all holding registers full → outputs go to their reset values immediately; no stale word appears after release.
- `window_size`=0 → `wrap` every cycle; with `rc_max_tx`=1, one channel still sends one word per cycle.

Source files
------------

// File: rtl/sd_dfc_pkg.sv
// Shared helpers for the DFC transmitter family: channel-id width, saturating
// counter increment and "zero means one/unlimited" normalisation.
package sd_dfc_pkg;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment a w-bit counter (held in 32 bits), sticking at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] top;
        top = (32'h1 << w) - 32'h1;
        return (v == top) ? v : v + 32'h1;
    endfunction

    function automatic logic [31:0] norm_one(input logic [31:0] v);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    function automatic logic is_unlimited(input logic [31:0] v);
        return (v == 32'h0);
    endfunction

endpackage

// File: rtl/sd_dfc_rc_chan.sv
// One virtual channel: holding register, per-window transfer/flow-control
// counters and eligibility. Monitor logic present only with SD_DFC_MRCTX_MON_EN.
module sd_dfc_rc_chan import sd_dfc_pkg::*; #(
    parameter int width     = 8,
    parameter int rc_ctr_sz = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrap,
    input  logic                 grant,
    input  logic                 fc_q,
    input  logic [rc_ctr_sz-1:0] rc_max_tx,
    input  logic [rc_ctr_sz-1:0] mon_fc_thd,
    input  logic                 c_srdy,
    output logic                 c_drdy,
    input  logic [width-1:0]     c_data,
    output logic [width-1:0]     hold_data,
    output logic                 elig,
    output logic                 mon_triggered
);

    logic                 hold_vld;
    logic [rc_ctr_sz-1:0] tx_ctr;
    logic                 limit;

    // Refill is allowed in the grant cycle so one channel can stream back to back.
    assign c_drdy = ~hold_vld | grant;
    assign limit  = ~is_unlimited(32'(rc_max_tx)) & (tx_ctr >= rc_max_tx);
    assign elig   = hold_vld & fc_q & ~limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (c_srdy & c_drdy) begin
            hold_vld  <= 1'b1;
            hold_data <= c_data;
        end else if (grant) begin
            hold_vld  <= 1'b0;
        end
    end

    // A grant in the wrap cycle belongs to the closing window and is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_ctr <= '0;
        else if (wrap)
            tx_ctr <= '0;
        else if (grant)
            tx_ctr <= rc_ctr_sz'(sat_inc(32'(tx_ctr), rc_ctr_sz));
    end

`ifdef SD_DFC_MRCTX_MON_EN
    logic [rc_ctr_sz-1:0] fc_ctr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_ctr        <= '0;
            mon_triggered <= 1'b0;
        end else if (wrap) begin
            fc_ctr        <= '0;
            mon_triggered <= 1'b0;
        end else begin
            if (hold_vld & ~fc_q)
                fc_ctr <= rc_ctr_sz'(sat_inc(32'(fc_ctr), rc_ctr_sz));
            if (fc_ctr > mon_fc_thd)
                mon_triggered <= 1'b1;
        end
    end
`else
    logic unused_mon;
    assign unused_mon    = ^mon_fc_thd;
    assign mon_triggered = 1'b0;
`endif

endmodule

// File: rtl/sd_dfc_mrctx.sv
// Multi-channel rate-controlled DFC transmitter: per-channel holding registers,
// round-robin arbitration onto one link. Optional monitor: SD_DFC_MRCTX_MON_EN.
module sd_dfc_mrctx import sd_dfc_pkg::*; #(
    parameter int channels  = 4,
    parameter int width     = 8,
    parameter int rc_ctr_sz = 8,
    parameter int chan_sz   = chan_width(channels)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [rc_ctr_sz-1:0]          window_size,
    input  logic [channels*rc_ctr_sz-1:0] rc_max_tx,
    input  logic [channels*rc_ctr_sz-1:0] mon_fc_thd,
    output logic [channels-1:0]           mon_triggered,
    input  logic [channels-1:0]           c_srdy,
    output logic [channels-1:0]           c_drdy,
    input  logic [channels*width-1:0]     c_data,
    output logic                          p_vld,
    output logic [chan_sz-1:0]            p_chan,
    output logic [width-1:0]              p_data,
    input  logic [channels-1:0]           p_fc_n
);

    logic [rc_ctr_sz-1:0] win_ctr;
    logic [rc_ctr_sz-1:0] win_last;
    logic                 wrap;
    logic [channels-1:0]  fc_q;
    logic [channels-1:0]  elig;
    logic [channels-1:0]  grant;
    logic [width-1:0]     hold_data [channels];
    logic [chan_sz-1:0]   rr_ptr;
    logic [chan_sz-1:0]   gnt_idx;
    logic                 found;
    int                   cand;

    // ">=" rather than "==" so a shrunken window_size forces an immediate wrap.
    assign win_last = rc_ctr_sz'(norm_one(32'(window_size)) - 32'h1);
    assign wrap     = (win_ctr >= win_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_ctr <= '0;
            fc_q    <= '0;
        end else begin
            win_ctr <= wrap ? '0 : win_ctr + 1'b1;
            fc_q    <= p_fc_n;
        end
    end

    for (genvar k = 0; k < channels; k++) begin : g_chan
        sd_dfc_rc_chan #(
            .width     (width),
            .rc_ctr_sz (rc_ctr_sz)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .wrap          (wrap),
            .grant         (grant[k]),
            .fc_q          (fc_q[k]),
            .rc_max_tx     (rc_max_tx[k*rc_ctr_sz +: rc_ctr_sz]),
            .mon_fc_thd    (mon_fc_thd[k*rc_ctr_sz +: rc_ctr_sz]),
            .c_srdy        (c_srdy[k]),
            .c_drdy        (c_drdy[k]),
            .c_data        (c_data[k*width +: width]),
            .hold_data     (hold_data[k]),
            .elig          (elig[k]),
            .mon_triggered (mon_triggered[k])
        );
    end

    // Search upward from rr_ptr, modulo channels; first eligible wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < channels; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= channels)
                cand = cand - channels;
            if (!found && elig[cand[chan_sz-1:0]]) begin
                found                   = 1'b1;
                gnt_idx                 = cand[chan_sz-1:0];
                grant[cand[chan_sz-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (found)
            rr_ptr <= (gnt_idx == chan_sz'(channels - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign p_vld  = found;
    assign p_chan = gnt_idx;
    assign p_data = found ? hold_data[gnt_idx] : '0;

endmodule

// File: tb/tb_sd_dfc_mrctx.sv
// Scoreboard bench for sd_dfc_mrctx (4 channels, 8-bit data, 8-bit counters).
module tb_sd_dfc_mrctx;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  window_size;
    logic [31:0] rc_max_tx;
    logic [31:0] mon_fc_thd;
    logic [3:0]  mon_triggered;
    logic [3:0]  c_srdy;
    logic [3:0]  c_drdy;
    logic [31:0] c_data;
    logic        p_vld;
    logic [1:0]  p_chan;
    logic [7:0]  p_data;
    logic [3:0]  p_fc_n;

    exp_t        q[$];
    exp_t        e;
    int          tests = 0;
    int          failed = 0;
    int          src_cnt[4];
    int          src_max[4];
    logic [7:0]  src_base[4];
    logic [3:0]  fc_seen;

`ifdef SD_DFC_MRCTX_MON_EN
    localparam logic [3:0] MON_HI = 4'b0001;
`else
    localparam logic [3:0] MON_HI = 4'b0000;
`endif

    sd_dfc_mrctx dut (
        .clk           (clk),
        .rst           (rst),
        .window_size   (window_size),
        .rc_max_tx     (rc_max_tx),
        .mon_fc_thd    (mon_fc_thd),
        .mon_triggered (mon_triggered),
        .c_srdy        (c_srdy),
        .c_drdy        (c_drdy),
        .c_data        (c_data),
        .p_vld         (p_vld),
        .p_chan        (p_chan),
        .p_data        (p_data),
        .p_fc_n        (p_fc_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int ch, input int n);
        exp_t x;
        x.chan = 2'(ch);
        x.data = 8'(8'h80 + 16 * ch + n);
        q.push_back(x);
    endtask

    task automatic begin_test(input logic [7:0] ws, input logic [31:0] rc, input logic [31:0] thd,
                              input logic [3:0] fc, input int m0, input int m1, input int m2, input int m3);
        rst         = 1'b1;
        window_size = ws;
        rc_max_tx   = rc;
        mon_fc_thd  = thd;
        p_fc_n      = fc;
        src_max[0]  = m0;
        src_max[1]  = m1;
        src_max[2]  = m2;
        src_max[3]  = m3;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        chk(name, q.size(), 0);
        cyc(3);
    endtask

    // Source side: channel k offers words base+n for n < src_max[k].
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) src_cnt[k] = 0;
            c_srdy = 4'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (src_cnt[k] < src_max[k]) begin
                    c_srdy[k]        = 1'b1;
                    c_data[k*8 +: 8] = 8'(src_base[k] + src_cnt[k]);
                end else begin
                    c_srdy[k] = 1'b0;
                end
            end
            #1;
            for (int k = 0; k < 4; k++)
                if (c_srdy[k] && c_drdy[k]) src_cnt[k]++;
        end
    end

    always @(posedge clk) fc_seen <= p_fc_n;

    always @(negedge clk) begin
        if (!rst && p_vld) begin
            if (q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL stray_word: got chan %0d data %0h, required no word", p_chan, p_data);
            end else begin
                e = q.pop_front();
                chk("word_chan", 32'(p_chan), 32'(e.chan));
                chk("word_data", 32'(p_data), 32'(e.data));
                chk("dfc_rule", 32'(fc_seen[p_chan]), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

    initial begin
        int vc, w0, w1;
        window_size = 8'd0;
        rc_max_tx   = 32'h0;
        mon_fc_thd  = 32'h0;
        p_fc_n      = 4'h0;
        c_data      = 32'h0;
        for (int k = 0; k < 4; k++) begin
            src_max[k]  = 0;
            src_base[k] = 8'(8'h80 + 16 * k);
        end
        cyc(2);
        chk("rst_drdy", 32'(c_drdy), 32'hF);
        chk("rst_vld", 32'(p_vld), 32'd0);
        chk("rst_chan", 32'(p_chan), 32'd0);
        chk("rst_data", 32'(p_data), 32'd0);
        chk("rst_mon", 32'(mon_triggered), 32'd0);

        // Round robin, all channels busy, one word per cycle.
        begin_test(8'd20, 32'h0, 32'hFFFF_FFFF, 4'hF, 3, 3, 3, 3);
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < 4; k++) push(k, n);
        cyc(1);
        vc = 0;
        for (int i = 0; i < 12; i++) begin
            if (p_vld) vc++;
            cyc(1);
        end
        chk("t1_tput", vc, 12);
        drain("t1_drain", 20);

        // Rate limit: 3 words per 10-cycle window on channel 1.
        begin_test(8'd10, 32'h0000_0300, 32'hFFFF_FFFF, 4'hF, 0, 8, 0, 0);
        for (int n = 0; n < 8; n++) push(1, n);
        w0 = 0;
        w1 = 0;
        for (int i = 0; i < 20; i++) begin
            if (p_vld) begin
                if (i < 10) w0++;
                else w1++;
            end
            if (i == 5) chk("t2_drdy_limited", 32'(c_drdy[1]), 32'd0);
            cyc(1);
        end
        chk("t2_win0", w0, 3);
        chk("t2_win1", w1, 3);
        drain("t2_drain", 30);

        // Flow control drop on channel 2 at cycle 5, restored at cycle 14.
        begin_test(8'd20, 32'h0, 32'hFFFF_FFFF, 4'hF, 3, 3, 3, 3);
        for (int k = 0; k < 4; k++) push(k, 0);
        push(0, 1); push(1, 1); push(3, 1);
        push(0, 2); push(1, 2); push(3, 2);
        push(2, 1); push(2, 2);
        cyc(5);
        p_fc_n = 4'b1011;
        cyc(2);
        chk("t3_skip2", 32'(p_chan), 32'd3);
        cyc(5);
        chk("t3_blocked_vld", 32'(p_vld), 32'd0);
        chk("t3_blocked_drdy", 32'(c_drdy[2]), 32'd0);
        cyc(2);
        p_fc_n = 4'hF;
        drain("t3_drain", 20);

        // Flow-control monitor on channel 0, threshold 4, window 16.
        begin_test(8'd16, 32'h0, 32'h0000_0004, 4'b1110, 1, 0, 0, 0);
        push(0, 0);
        cyc(6);
        chk("t4_mon_c6", 32'(mon_triggered), 32'd0);
        cyc(1);
        chk("t4_mon_c7", 32'(mon_triggered), 32'(MON_HI));
        cyc(8);
        chk("t4_mon_c15", 32'(mon_triggered), 32'(MON_HI));
        cyc(1);
        chk("t4_mon_c16", 32'(mon_triggered), 32'd0);
        cyc(5);
        chk("t4_mon_c21", 32'(mon_triggered), 32'd0);
        cyc(1);
        chk("t4_mon_c22", 32'(mon_triggered), 32'(MON_HI));
        p_fc_n = 4'hF;
        drain("t4_drain", 10);

        // Reset with all holding registers full and a word on the link.
        begin_test(8'd20, 32'h0, 32'hFFFF_FFFF, 4'h0, 1, 1, 1, 1);
        cyc(3);
        chk("t5_full", 32'(c_drdy), 32'd0);
        p_fc_n = 4'hF;
        cyc(1);
        chk("t5_pre_vld", 32'(p_vld), 32'd1);
        chk("t5_pre_data", 32'(p_data), 32'h80);
        rst = 1'b1;
        #1;
        chk("t5_rst_drdy", 32'(c_drdy), 32'hF);
        chk("t5_rst_vld", 32'(p_vld), 32'd0);
        chk("t5_rst_data", 32'(p_data), 32'd0);
        chk("t5_rst_chan", 32'(p_chan), 32'd0);
        for (int k = 0; k < 4; k++) src_max[k] = 0;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        chk("t5_idle", 32'(p_vld), 32'd0);

        // Zero window: wrap every cycle, limit 1 never throttles.
        begin_test(8'd0, 32'h0000_0001, 32'hFFFF_FFFF, 4'hF, 5, 0, 0, 0);
        for (int n = 0; n < 5; n++) push(0, n);
        cyc(1);
        vc = 0;
        for (int i = 0; i < 5; i++) begin
            if (p_vld) vc++;
            cyc(1);
        end
        chk("t6_tput", vc, 5);
        drain("t6_drain", 10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
